// File: rtl/icache_refill_if.sv
// Refill engine bundle: fetch-side miss request, memory read port and
// cache tag/data array write port.
//   master : the refill engine (drives busy/done, mem_req/mem_addr, array writes)
//   slave  : the surrounding fetch stage / memory / arrays
interface icache_refill_if #(
  parameter int TAG_W      = 22,
  parameter int LINE_BYTES = 8
);
  localparam int WORDS   = LINE_BYTES / 4;
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W = 32 - TAG_W - OFF_W;
  localparam int WORD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic               miss_req;
  logic [31:0]        miss_addr;
  logic               abort;
  logic               busy;
  logic               refill_done;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ready;
  logic [31:0]        mem_rdata;
  logic               cache_we;
  logic [INDEX_W-1:0] cache_index;
  logic [WORD_W-1:0]  cache_word;
  logic [31:0]        cache_wdata;
  logic               tag_we;
  logic [TAG_W-1:0]   tag_wdata;
  logic               tag_valid;

  modport master (
    input  miss_req, miss_addr, abort, mem_ready, mem_rdata,
    output busy, refill_done, mem_req, mem_addr, cache_we, cache_index,
           cache_word, cache_wdata, tag_we, tag_wdata, tag_valid
  );

  modport slave (
    output miss_req, miss_addr, abort, mem_ready, mem_rdata,
    input  busy, refill_done, mem_req, mem_addr, cache_we, cache_index,
           cache_word, cache_wdata, tag_we, tag_wdata, tag_valid
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction cache refill engine. On a fetch miss it invalidates the line's
// tag, fetches the line critical word first (wrapping within the line),
// writes each word into the data array, then writes the tag valid and pulses
// refill_done so fetch can replay.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   bus   : icache_refill_if.master (miss request, memory port, array writes)
//
// state | meaning
// IDLE  | waiting for a miss request
// INVAL | write tag with valid=0 so a partial line can never hit
// FILL  | fetch words from memory, one data write per accepted beat
// TAGW  | write tag with valid=1
// DONE  | one-cycle refill_done pulse
module icache_refill #(
  parameter int TAG_W      = 22,
  parameter int LINE_BYTES = 8
) (
  input logic            clk,
  input logic            reset,
  icache_refill_if.master bus
);
  localparam int WORDS   = LINE_BYTES / 4;
  localparam int OFF_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W = 32 - TAG_W - OFF_W;
  localparam int WORD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {IDLE, INVAL, FILL, TAGW, DONE} state_t;

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [WORD_W-1:0]  w0_q;
  logic [WORD_W-1:0]  beat_q;
  logic [WORD_W-1:0]  cur_word;
  logic [31:0]        line_base;
  logic               accept;
  logic               last_beat;

  assign accept    = (state == IDLE) && bus.miss_req && !bus.abort;
  // Truncation to WORD_W bits gives the wrap within the line.
  assign cur_word  = w0_q + beat_q;
  assign last_beat = (beat_q == WORD_W'(WORDS - 1));
  assign line_base = {tag_q, idx_q, {OFF_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      tag_q  <= '0;
      idx_q  <= '0;
      w0_q   <= '0;
      beat_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tag_q  <= bus.miss_addr[31 -: TAG_W];
        idx_q  <= bus.miss_addr[OFF_W +: INDEX_W];
        w0_q   <= (WORDS > 1) ? WORD_W'(bus.miss_addr >> 2) : '0;
        beat_q <= '0;
      end else if (state == FILL && bus.mem_ready) begin
        beat_q <= beat_q + WORD_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.busy        = 1'b0;
    bus.refill_done = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_addr    = '0;
    bus.cache_we    = 1'b0;
    bus.cache_index = '0;
    bus.cache_word  = '0;
    bus.cache_wdata = '0;
    bus.tag_we      = 1'b0;
    bus.tag_wdata   = '0;
    bus.tag_valid   = 1'b0;

    // Index and tag are held steady for the whole refill.
    if (state != IDLE) begin
      bus.busy        = 1'b1;
      bus.cache_index = idx_q;
      bus.tag_wdata   = tag_q;
    end

    case (state)
      IDLE: begin
        if (accept) state_nxt = INVAL;
      end
      INVAL: begin
        // The invalidate is issued even if abort arrives this cycle.
        bus.tag_we = 1'b1;
        state_nxt  = bus.abort ? IDLE : FILL;
      end
      FILL: begin
        bus.mem_req    = 1'b1;
        bus.mem_addr   = line_base | (32'(cur_word) << 2);
        bus.cache_word = cur_word;
        // A beat arriving with abort is still written; nothing after it.
        if (bus.mem_ready) begin
          bus.cache_we    = 1'b1;
          bus.cache_wdata = bus.mem_rdata;
          if (last_beat) state_nxt = TAGW;
        end
        if (bus.abort) state_nxt = IDLE;
      end
      TAGW: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else begin
          bus.tag_we    = 1'b1;
          bus.tag_valid = 1'b1;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        bus.refill_done = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
Refill engine that writes the fetch-stage instruction cache's tag and data arrays; the fetch stage is the reader of those arrays. On a fetch miss it fetches the missing line from instruction memory, critical word first with wrap. It writes each word into the cache data array, then writes the tag with valid=1. It sits between the fetch-stage cache and the memory port and signals completion so fetch can replay the access.

Parameters:
TAG_W, 22, tag width; tag = addr[31:32-TAG_W]
LINE_BYTES, 8, bytes per line; power of 2, >=4
WORDS, LINE_BYTES/4, 32-bit words per line (derived, not overridable)
INDEX_W, 32-TAG_W-log2(LINE_BYTES), set index width (derived; 7 at defaults)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
miss_req  in  1  fetch miss request; level, sampled only in IDLE
miss_addr  in  32  missing fetch address; captured when request accepted
abort  in  1  flush/redirect; cancels an in-progress refill
busy  out  1  high in every state except IDLE
refill_done  out  1  one-cycle pulse when line is valid in cache
mem_req  out  1  word read request to memory
mem_addr  out  32  word-aligned read address (bits[1:0]=0)
mem_ready  in  1  memory returns mem_rdata this cycle for current mem_addr
mem_rdata  in  32  read word, big-endian: byte0 = bits[31:24]
cache_we  out  1  data array word write strobe
cache_index  out  INDEX_W  line index for data/tag write
cache_word  out  log2(WORDS)  word slot within line
cache_wdata  out  32  word to write; byte lane k of slot = cache_wdata[31-8k -: 8]
tag_we  out  1  tag array write strobe
tag_wdata  out  TAG_W  tag to write
tag_valid  out  1  valid bit written with tag

Behaviour:
- Reset (reset==0 at rising edge): state IDLE; busy, refill_done, mem_req, cache_we, tag_we, tag_valid = 0; mem_addr, cache_index, cache_word, cache_wdata, tag_wdata = 0. Reset overrides everything, including mid-refill. No tag write on reset.
- FSM states: IDLE, INVAL, FILL, TAGW, DONE.
- IDLE: if miss_req=1 and abort=0, capture tag = miss_addr[31:32-TAG_W], index, start word w0 = miss_addr word offset, beat count = 0, then go to INVAL. abort=1 in IDLE has no effect, and the request is not accepted that cycle.
- INVAL (1 cycle): tag_we=1, tag_valid=0, tag_wdata = captured tag. A partially filled line can therefore never hit. Next state: FILL.
- FILL: mem_req=1 and mem_addr = {tag, index, cur_word, 2'b00}, with cur_word = (w0 + beat) mod WORDS (wraps within the line). On a cycle with mem_ready=1: cache_we=1 (combinational with mem_ready), cache_word = cur_word, cache_wdata = mem_rdata, and beat increments. The last beat (beat==WORDS-1) goes to TAGW. With mem_ready=0, outputs hold and no write occurs; there is no timeout.
- TAGW (1 cycle): tag_we=1, tag_valid=1. Next state: DONE.
- DONE (1 cycle): refill_done=1. Next state: IDLE. A new miss_req can be accepted on the cycle after DONE.
- Abort: abort=1 in INVAL, FILL or TAGW returns to IDLE next cycle. No further cache_we/tag_we is issued, except that the INVAL write already issued stands. abort in the same cycle as a FILL beat with mem_ready=1: that beat's data write still occurs, and nothing after it. No refill_done for an aborted refill. abort in DONE is ignored; the pulse still fires.
- Latency with mem_ready held high: request sampled at cycle T, INVAL at T+1, FILL T+2..T+1+WORDS, TAGW at T+2+WORDS, refill_done at T+3+WORDS (T+5 at defaults).
- cache_index and tag_wdata are stable from INVAL through DONE.
- mem_addr is always word-aligned; miss_addr[1:0] is ignored.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1; miss_req=0 -> all outputs 0, busy=0 for 10 cycles.
- Basic refill: miss_addr=0x00000400, mem_ready=1, rdata 0x0FF03C03 then 0x1400FC17 -> tag_we(valid=0) at T+1. Writes word0=0x0FF03C03, word1=0x1400FC17 at index 0. Tag 0x000001 written valid=1 at T+4. refill_done at T+5.
- Critical word first with wrap: miss_addr=0x00000404 -> mem_addr sequence 0x404 then 0x400, with cache_word 1 then 0.
- Memory stalls: same as basic refill, but mem_ready low for 3 cycles before each beat -> mem_addr held, no cache_we while low, refill_done at T+11.
- Abort mid-fill: abort=1 on the first FILL beat with mem_ready=1 -> word written once, no tag valid=1 write, no refill_done, busy=0 next cycle.
- Reset mid-refill: reset=0 during FILL -> IDLE next cycle, all outputs 0; a new miss then completes normally.
